// File: rtl/pipe_control_unit.sv
// Decode/issue control for a two-stage (EX, WB) pipeline with jump squashing,
// stall/flush handling and a saturating illegal-opcode counter.
module pipe_control_unit #(
  parameter int OPC_W       = 2,
  parameter int JMP_BUBBLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_in_ready,
  output logic             o_id_adr_sel,
  output logic             o_ex_valid,
  output logic [1:0]       o_ex_alu_ctrl,
  output logic             o_ex_imm_sel,
  output logic             o_ex_data2_sel,
  output logic             o_wb_valid,
  output logic             o_wb_reg_write,
  output logic             o_wb_output_sel,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_SQUASH = 1'b1;
  localparam logic [2:0] BUBBLES  = 3'(JMP_BUBBLES);

  logic [0:0]       r_state;
  logic [2:0]       r_sq_cnt;
  logic             r_ex_valid, r_ex_imm_sel, r_ex_data2_sel, r_ex_reg_write, r_ex_output_sel;
  logic [1:0]       r_ex_alu_ctrl;
  logic             r_wb_valid, r_wb_reg_write, r_wb_output_sel;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic w_upper_zero, w_is_li, w_is_sll, w_is_j, w_legal;
  logic w_accept, w_take, w_ex_load, w_jump, w_illegal;

  // Opcode bits above [1:0] must be zero for any legal instruction.
  assign w_upper_zero = ((i_opcode >> 2) == '0);
  assign w_is_li      = w_upper_zero & (i_opcode[1:0] == 2'd0);
  assign w_is_sll     = w_upper_zero & (i_opcode[1:0] == 2'd1);
  assign w_is_j       = w_upper_zero & (i_opcode[1:0] == 2'd3);
  assign w_legal      = w_is_li | w_is_sll | w_is_j;

  assign o_in_ready = ~i_stall & ~i_flush;
  assign w_accept   = i_in_valid & o_in_ready;
  // While squashing, accepted slots are consumed but have no effect.
  assign w_take     = w_accept & (r_state == S_RUN);
  assign w_ex_load  = w_take & (w_is_li | w_is_sll);
  assign w_jump     = w_take & w_is_j;
  assign w_illegal  = w_take & ~w_legal;

  assign o_id_adr_sel = w_jump;
  assign o_illegal    = w_illegal & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_alu_ctrl   <= 2'b00;
      r_ex_imm_sel    <= 1'b0;
      r_ex_data2_sel  <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_output_sel <= 1'b0;
    end else if (i_flush) begin
      r_ex_valid      <= 1'b0;
      r_ex_alu_ctrl   <= 2'b00;
      r_ex_imm_sel    <= 1'b0;
      r_ex_data2_sel  <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_output_sel <= 1'b0;
    end else if (!i_stall) begin
      r_ex_valid      <= w_ex_load;
      r_ex_alu_ctrl   <= {1'b0, w_ex_load & w_is_sll};
      r_ex_imm_sel    <= w_ex_load & w_is_li;
      r_ex_data2_sel  <= w_ex_load & w_is_sll;
      r_ex_reg_write  <= w_ex_load;
      r_ex_output_sel <= w_ex_load & w_is_sll;
    end
  end

  // WB still advances on flush so the instruction already in EX retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_output_sel <= 1'b0;
    end else if (i_flush || !i_stall) begin
      r_wb_valid      <= r_ex_valid;
      r_wb_reg_write  <= r_ex_reg_write;
      r_wb_output_sel <= r_ex_output_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_sq_cnt <= 3'd0;
    end else if (i_flush) begin
      r_state  <= S_RUN;
      r_sq_cnt <= 3'd0;
    end else if (!i_stall) begin
      case (r_state)
        S_RUN: begin
          if (w_jump && (BUBBLES != 3'd0)) begin
            r_state  <= S_SQUASH;
            r_sq_cnt <= BUBBLES;
          end
        end
        default: begin
          r_sq_cnt <= r_sq_cnt - 3'd1;
          if (r_sq_cnt <= 3'd1) begin
            r_state  <= S_RUN;
            r_sq_cnt <= 3'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_illegal && (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

  assign o_ex_valid      = r_ex_valid;
  assign o_ex_alu_ctrl   = r_ex_alu_ctrl;
  assign o_ex_imm_sel    = r_ex_imm_sel;
  assign o_ex_data2_sel  = r_ex_data2_sel;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_reg_write  = r_wb_reg_write & r_wb_valid;
  assign o_wb_output_sel = r_wb_output_sel;
  assign o_illegal_cnt   = r_illegal_cnt;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: two instances (default parameters and
// OPC_W=4/CNT_W=1/JMP_BUBBLES=3) with WB-stage scoreboards.
module tb_pipe_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid, a_stall, a_flush;
  logic [1:0] a_opcode;
  logic       a_in_ready, a_id_adr_sel, a_ex_valid, a_ex_imm, a_ex_d2;
  logic [1:0] a_ex_alu;
  logic       a_wb_valid, a_wb_rw, a_wb_os, a_illegal;
  logic [7:0] a_illegal_cnt;

  logic       b_in_valid, b_stall, b_flush;
  logic [3:0] b_opcode;
  logic       b_in_ready, b_id_adr_sel, b_ex_valid, b_ex_imm, b_ex_d2;
  logic [1:0] b_ex_alu;
  logic       b_wb_valid, b_wb_rw, b_wb_os, b_illegal;
  logic [0:0] b_illegal_cnt;

  int n_checks = 0;
  int n_err    = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  localparam logic [1:0] WB_LI  = 2'b10;
  localparam logic [1:0] WB_SLL = 2'b11;

  pipe_control_unit u_a (
    .clk(clk), .rst_n(rst_n), .i_in_valid(a_in_valid), .i_opcode(a_opcode),
    .i_stall(a_stall), .i_flush(a_flush), .o_in_ready(a_in_ready),
    .o_id_adr_sel(a_id_adr_sel), .o_ex_valid(a_ex_valid), .o_ex_alu_ctrl(a_ex_alu),
    .o_ex_imm_sel(a_ex_imm), .o_ex_data2_sel(a_ex_d2), .o_wb_valid(a_wb_valid),
    .o_wb_reg_write(a_wb_rw), .o_wb_output_sel(a_wb_os), .o_illegal(a_illegal),
    .o_illegal_cnt(a_illegal_cnt)
  );

  pipe_control_unit #(.OPC_W(4), .JMP_BUBBLES(3), .CNT_W(1)) u_b (
    .clk(clk), .rst_n(rst_n), .i_in_valid(b_in_valid), .i_opcode(b_opcode),
    .i_stall(b_stall), .i_flush(b_flush), .o_in_ready(b_in_ready),
    .o_id_adr_sel(b_id_adr_sel), .o_ex_valid(b_ex_valid), .o_ex_alu_ctrl(b_ex_alu),
    .o_ex_imm_sel(b_ex_imm), .o_ex_data2_sel(b_ex_d2), .o_wb_valid(b_wb_valid),
    .o_wb_reg_write(b_wb_rw), .o_wb_output_sel(b_wb_os), .o_illegal(b_illegal),
    .o_illegal_cnt(b_illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // WB scoreboards: each retirement pops the oldest expected {reg_write, output_sel}.
  always @(negedge clk) begin
    if (rst_n && a_wb_valid) begin
      if (qa.size() == 0) chk("a_wb_unexpected", 32'(a_wb_valid), 0);
      else chk("a_wb_ctrl", 32'({a_wb_rw, a_wb_os}), 32'(qa.pop_front()));
    end
    if (rst_n && b_wb_valid) begin
      if (qb.size() == 0) chk("b_wb_unexpected", 32'(b_wb_valid), 0);
      else chk("b_wb_ctrl", 32'({b_wb_rw, b_wb_os}), 32'(qb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_in_valid = 1'b1; a_opcode = 2'd2; a_stall = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b1; b_opcode = 4'd2; b_stall = 1'b0; b_flush = 1'b0;
    #3;
    chk("rst_a_ex_valid", 32'(a_ex_valid), 0);
    chk("rst_a_wb_valid", 32'(a_wb_valid), 0);
    chk("rst_a_illegal", 32'(a_illegal), 0);
    chk("rst_b_illegal", 32'(b_illegal), 0);
    tick(); tick();
    chk("rst_a_cnt_held", 32'(a_illegal_cnt), 0);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // LI through the pipe
    a_in_valid = 1'b1; a_opcode = 2'd0; qa.push_back(WB_LI);
    #1;
    chk("li_in_ready", 32'(a_in_ready), 1);
    chk("li_adr_sel", 32'(a_id_adr_sel), 0);
    tick(); a_in_valid = 1'b0; #1;
    chk("li_ex_valid", 32'(a_ex_valid), 1);
    chk("li_ex_imm", 32'(a_ex_imm), 1);
    chk("li_ex_alu", 32'(a_ex_alu), 0);
    chk("li_ex_d2", 32'(a_ex_d2), 0);
    chk("li_wb_early", 32'(a_wb_valid), 0);
    tick(); #1;
    chk("li_wb_valid", 32'(a_wb_valid), 1);
    chk("li_wb_rw", 32'(a_wb_rw), 1);
    chk("li_wb_os", 32'(a_wb_os), 0);
    tick(); #1;
    chk("idle_wb_rw", 32'(a_wb_rw), 0);

    // SLL through the pipe
    a_in_valid = 1'b1; a_opcode = 2'd1; qa.push_back(WB_SLL);
    tick(); a_in_valid = 1'b0; #1;
    chk("sll_ex_alu", 32'(a_ex_alu), 1);
    chk("sll_ex_d2", 32'(a_ex_d2), 1);
    chk("sll_ex_imm", 32'(a_ex_imm), 0);
    tick(); #1;
    chk("sll_wb_os", 32'(a_wb_os), 1);
    chk("sll_wb_rw", 32'(a_wb_rw), 1);
    tick();

    // J then SLL back-to-back, one bubble
    a_in_valid = 1'b1; a_opcode = 2'd3; #1;
    chk("j_adr_sel", 32'(a_id_adr_sel), 1);
    tick(); a_opcode = 2'd1; #1;
    chk("sq_adr_sel", 32'(a_id_adr_sel), 0);
    chk("j_no_ex", 32'(a_ex_valid), 0);
    tick(); a_opcode = 2'd0; qa.push_back(WB_LI); #1;
    chk("sll_dropped", 32'(a_ex_valid), 0);
    tick(); a_in_valid = 1'b0; #1;
    chk("post_j_li_ex", 32'(a_ex_valid), 1);
    chk("post_j_li_imm", 32'(a_ex_imm), 1);
    tick(); tick();

    // LI then two stall cycles
    a_in_valid = 1'b1; a_opcode = 2'd0; qa.push_back(WB_LI);
    tick(); a_in_valid = 1'b0; a_stall = 1'b1; #1;
    chk("stall_in_ready", 32'(a_in_ready), 0);
    chk("stall_ex_held1", 32'(a_ex_valid), 1);
    tick(); a_in_valid = 1'b1; a_opcode = 2'd3; #1;
    chk("stall_ex_held2", 32'(a_ex_valid), 1);
    chk("stall_wb_held", 32'(a_wb_valid), 0);
    chk("stall_adr_sel", 32'(a_id_adr_sel), 0);
    a_opcode = 2'd2; #1;
    chk("stall_illegal", 32'(a_illegal), 0);
    tick(); a_in_valid = 1'b0; a_stall = 1'b0; #1;
    chk("stall_ex_held3", 32'(a_ex_valid), 1);
    chk("stall_wb_cyc3", 32'(a_wb_valid), 0);
    tick(); #1;
    chk("stall_wb_cyc4", 32'(a_wb_valid), 1);
    tick();

    // illegal opcode on default instance
    a_in_valid = 1'b1; a_opcode = 2'd2; #1;
    chk("a_illegal_pulse", 32'(a_illegal), 1);
    tick(); a_in_valid = 1'b0; #1;
    chk("a_illegal_cnt", 32'(a_illegal_cnt), 1);
    chk("a_illegal_no_ex", 32'(a_ex_valid), 0);
    chk("a_illegal_low", 32'(a_illegal), 0);
    tick();

    // flush together with stall: EX cleared, WB still retires the LI
    a_in_valid = 1'b1; a_opcode = 2'd0; qa.push_back(WB_LI);
    tick(); a_in_valid = 1'b0; a_flush = 1'b1; a_stall = 1'b1; #1;
    chk("flush_in_ready", 32'(a_in_ready), 0);
    tick(); a_flush = 1'b0; a_stall = 1'b0; #1;
    chk("flush_ex_clear", 32'(a_ex_valid), 0);
    chk("flush_wb_load", 32'(a_wb_valid), 1);
    tick(); tick();

    // OPC_W=4 illegal opcodes 2 and 4, CNT_W=1 saturation
    b_in_valid = 1'b1; b_opcode = 4'd2; #1;
    chk("b_ill2_pulse", 32'(b_illegal), 1);
    tick(); b_opcode = 4'd4; #1;
    chk("b_ill4_pulse", 32'(b_illegal), 1);
    chk("b_cnt_one", 32'(b_illegal_cnt), 1);
    chk("b_ill_no_ex1", 32'(b_ex_valid), 0);
    tick(); b_in_valid = 1'b0; #1;
    chk("b_cnt_sat", 32'(b_illegal_cnt), 1);
    chk("b_ill_no_ex2", 32'(b_ex_valid), 0);
    chk("b_ill_low", 32'(b_illegal), 0);
    tick();

    // J with three bubbles
    b_in_valid = 1'b1; b_opcode = 4'd3; #1;
    chk("b_j_adr_sel", 32'(b_id_adr_sel), 1);
    tick(); #1;
    chk("b_sq_j_adr_sel", 32'(b_id_adr_sel), 0);
    tick(); b_opcode = 4'd2; #1;
    chk("b_sq_no_illegal", 32'(b_illegal), 0);
    chk("b_sq_ex1", 32'(b_ex_valid), 0);
    tick(); b_opcode = 4'd0; #1;
    chk("b_sq_ex2", 32'(b_ex_valid), 0);
    tick(); qb.push_back(WB_LI); #1;
    chk("b_sq_ex3", 32'(b_ex_valid), 0);
    tick(); b_in_valid = 1'b0; #1;
    chk("b_after_sq_ex", 32'(b_ex_valid), 1);
    chk("b_sq_cnt_kept", 32'(b_illegal_cnt), 1);
    tick(); tick();

    // J then flush: squash abandoned, next LI flows
    b_in_valid = 1'b1; b_opcode = 4'd3;
    tick(); b_opcode = 4'd0; b_flush = 1'b1; #1;
    chk("b_flush_ready", 32'(b_in_ready), 0);
    tick(); b_flush = 1'b0; qb.push_back(WB_LI); #1;
    chk("b_flush_run_ready", 32'(b_in_ready), 1);
    tick(); b_in_valid = 1'b0; #1;
    chk("b_flush_li_ex", 32'(b_ex_valid), 1);
    chk("b_flush_li_imm", 32'(b_ex_imm), 1);
    tick(); tick();

    // reset in the middle of a squash
    b_in_valid = 1'b1; b_opcode = 4'd3;
    tick(); b_in_valid = 1'b0; rst_n = 1'b0; #1;
    chk("midrst_cnt_clear", 32'(b_illegal_cnt), 0);
    chk("midrst_ex_valid", 32'(b_ex_valid), 0);
    tick(); rst_n = 1'b1; b_in_valid = 1'b1; b_opcode = 4'd0; qb.push_back(WB_LI);
    tick(); b_in_valid = 1'b0; #1;
    chk("midrst_li_ex", 32'(b_ex_valid), 1);
    tick(); tick();

    chk("a_sb_drained", 32'(qa.size()), 0);
    chk("b_sb_drained", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter OPC_W, default 2, opcode width (>=2); upper bits above [1:0] SHALL be zero for a legal opcode.
REQ-002 SHALL have parameter JMP_BUBBLES, default 1, slots squashed after an accepted J (0..7).
REQ-003 SHALL have parameter CNT_W, default 8, illegal-opcode counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decode slot holds an instruction.
REQ-007 opcode  in  OPC_W  instruction opcode.
REQ-008 stall  in  1  hold all pipeline state this cycle.
REQ-009 flush  in  1  kill in-flight instructions.
REQ-010 in_ready  out  1  decode slot consumed this cycle (= ~stall & ~flush).
REQ-011 id_adr_sel  out  1  combinational jump select to PC mux.
REQ-012 ex_valid, ex_alu_ctrl[1:0], ex_imm_sel, ex_data2_sel  out  EX-stage control.
REQ-013 wb_valid, wb_reg_write, wb_output_sel  out  WB-stage control.
REQ-014 illegal  out  1  one-cycle pulse, illegal opcode accepted.
REQ-015 illegal_cnt  out  CNT_W  saturating count of illegal opcodes.

Function
REQ-016 Decode: LI(0) -> reg_write=1, alu=00, output_sel=0, imm_sel=1, data2_sel=0; SLL(1) -> reg_write=1, alu=01, output_sel=1, imm_sel=0, data2_sel=1; J(3) -> reg_write=0, all others 0, jump; any other value illegal.
REQ-017 All unused/don't-care control fields SHALL be driven 0, never X.
REQ-018 Accept = in_valid & in_ready; only accepted, legal, non-squashed, non-J instructions SHALL enter EX with ex_valid=1.
REQ-019 EX -> WB latency exactly 1 cycle; decode -> WB latency 2 cycles absent stall.
REQ-020 Invalid stage SHALL present all its control outputs as 0 (wb_reg_write gated by wb_valid).
REQ-021 FSM states RUN, SQUASH; 3-bit squash counter.
REQ-022 RUN: id_adr_sel = accept & opcode==J; on such accept with JMP_BUBBLES>0 go SQUASH, counter=JMP_BUBBLES; JMP_BUBBLES=0 stays RUN.
REQ-023 SQUASH: id_adr_sel=0; each non-stalled, non-flushed cycle decrements counter and drops any accepted instruction (no EX entry, no illegal pulse); counter reaching 0 returns to RUN on that edge.
REQ-024 stall=1: EX, WB, FSM, counter hold; in_ready=0; id_adr_sel=0; illegal=0.
REQ-025 flush=1: ex_valid cleared, WB loads EX contents as normal, FSM forced to RUN, counter 0; flush wins over stall.
REQ-026 illegal pulses on accept of illegal opcode in RUN; illegal_cnt increments same edge, saturates at 2^CNT_W-1.

Reset
REQ-027 On rst_n low, immediately: ex_valid=wb_valid=0, all stage control=0, FSM=RUN, counter=0, illegal_cnt=0, illegal=0.
REQ-028 Reset mid-SQUASH or mid-stall SHALL discard all state; first cycle after release behaves as RUN.

Verification
REQ-029 Reset release, LI accepted cycle 0 -> ex_imm_sel=1 cycle 1; wb_valid=1, wb_reg_write=1, wb_output_sel=0 cycle 2.
REQ-030 SLL accepted -> ex_alu_ctrl=01, ex_data2_sel=1 cycle 1; wb_output_sel=1, wb_reg_write=1 cycle 2.
REQ-031 J then SLL back-to-back, JMP_BUBBLES=1 -> id_adr_sel=1 cycle 0 only; SLL dropped, ex_valid=0 cycles 1-2; next LI flows.
REQ-032 LI accepted, stall=1 cycles 1-2 -> EX LI held, in_ready=0; LI reaches WB cycle 4.
REQ-033 OPC_W=4, opcode 2 then 4, CNT_W=1 -> two illegal pulses, illegal_cnt=1 saturated, no EX entries.
REQ-034 J with JMP_BUBBLES=3, flush next cycle -> FSM RUN, following LI accepted and reaches EX.
